round_timer: RTL and testbench
==============================

ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter CLK_FREQ, default 75000000: pclk cycles per second tick; legal range 2..2^27.
REQ-002 Parameter ROUND_SEC, default 30: round length in seconds; legal range 1..99.
REQ-003 pclk  input  1  pixel clock; single clock domain; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 state  input  2  game state: 2'b00 IDLE, 2'b01 WAIT, 2'b10 GAME, 2'b11 SCORE.
REQ-006 running  output  1  high while a round countdown is active.
REQ-007 tick_1hz  output  1  one-cycle pulse on each seconds decrement.
REQ-008 sec_left  output  7  remaining seconds, unsigned binary.
REQ-009 time_up  output  1  one-cycle pulse when the countdown reaches zero; feeds the state machine as the GAME->SCORE request.
REQ-010 ascii_1  output  7  ASCII tens digit of sec_left.
REQ-011 ascii_0  output  7  ASCII units digit of sec_left.

Function
REQ-012 Internal state_q register holds state delayed one cycle; round start = (state==GAME) && (state_q!=GAME).
REQ-013 On the round-start edge: sec_left<=ROUND_SEC, prescaler<=0, running<=1, no tick_1hz, no time_up.
REQ-014 Prescaler is ceil(log2(CLK_FREQ)) bits wide; increments each cycle while running and state==GAME.
REQ-015 When prescaler==CLK_FREQ-1 and running: prescaler<=0, sec_left<=sec_left-1, tick_1hz<=1 for that one cycle.
REQ-016 First decrement occurs exactly CLK_FREQ cycles after the round-start edge; each later one CLK_FREQ cycles after the previous.
REQ-017 On the decrement from 1 to 0: time_up<=1 and running<=0 in the same registered update as sec_left<=0; time_up lasts exactly one cycle.
REQ-018 sec_left never wraps below 0; once running==0, prescaler and sec_left hold.
REQ-019 State leaving GAME while running (e.g. right-click abort to SCORE): running<=0 next cycle; sec_left frozen at current value; no time_up and no tick_1hz.
REQ-020 Re-entering GAME always restarts from ROUND_SEC, whether the previous round expired or was aborted.
REQ-021 Round start coincident with a would-be terminal count is impossible by construction: start has priority and reloads.
REQ-022 ascii_1 = 7'h30 + sec_left/10; ascii_0 = 7'h30 + sec_left%10; both registered, valid one cycle after sec_left changes.
REQ-023 Divide-by-10 is implemented for range 0..99 only; sec_left never exceeds 99.
REQ-024 All outputs are registered; no combinational path from state to any output.

Reset
REQ-025 With rst high at a pclk edge: running=0, tick_1hz=0, time_up=0, sec_left=0, ascii_1=7'h30, ascii_0=7'h30, prescaler=0, state_q=IDLE.
REQ-026 rst overrides every other event, including round start and terminal count in the same cycle.
REQ-027 If reset is released while state==GAME, a new round starts on the first post-reset cycle because state_q==IDLE.

Verification (CLK_FREQ=10, ROUND_SEC=3 unless noted)
REQ-028 Reset, then IDLE->GAME -> running=1, sec_left=3 one cycle later; ticks at +10, +20, +30 cycles; sec_left 2,1,0; time_up single pulse coincident with sec_left=0; running=0.
REQ-029 ROUND_SEC=30 entry -> ascii_1=7'h33, ascii_0=7'h30; after first tick -> 7'h32, 7'h39 one cycle after sec_left=29.
REQ-030 GAME->SCORE at cycle 15 of the round -> running=0, sec_left holds 2, no time_up for 100 further cycles.
REQ-031 Abort, then SCORE->GAME -> sec_left reloads to 3, prescaler restarts, first tick exactly 10 cycles after the new start edge.
REQ-032 rst asserted mid-round (sec_left=2) -> all outputs return to reset values next edge; state held at GAME through release -> new round starts with sec_left=3.
REQ-033 Hold GAME 200 cycles after expiry -> time_up and tick_1hz stay 0, sec_left stays 0.

Source files
------------

// File: rtl/round_timer.sv
// round_timer: per-round seconds countdown for the game state machine.
// Starts on entry into GAME, ticks once per CLK_FREQ cycles, pulses time_up
// when it reaches zero and freezes if GAME is left early. The remaining
// seconds are also presented as two registered ASCII digits for display.
`timescale 1ns/1ps
module round_timer #(
  parameter int CLK_FREQ  = 75000000,
  parameter int ROUND_SEC = 30
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [1:0] state,
  output logic       running,
  output logic       tick_1hz,
  output logic [6:0] sec_left,
  output logic       time_up,
  output logic [6:0] ascii_1,
  output logic [6:0] ascii_0
);

  // Prescaler is wide enough to hold CLK_FREQ-1; guard the degenerate width.
  localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [6:0]    SEC_INIT  = 7'(ROUND_SEC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } game_state_t;

  game_state_t   state_q, state_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          time_up_q, time_up_d;
  logic [6:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    ascii1_q, ascii1_d;
  logic [6:0]    ascii0_q, ascii0_d;

  logic in_game;
  logic start;
  logic terminal;

  assign in_game  = (game_state_t'(state) == ST_GAME);
  assign start    = in_game && (state_q != ST_GAME);
  assign terminal = running_q && in_game && (presc_q == PRESC_MAX);

  // Countdown next-state: start reloads, leaving GAME freezes, terminal count decrements.
  always_comb begin
    state_d   = game_state_t'(state);
    running_d = running_q;
    tick_d    = 1'b0;
    time_up_d = 1'b0;
    sec_d     = sec_q;
    presc_d   = presc_q;
    if (start) begin
      // A start always wins, even over a coincident terminal count.
      sec_d     = SEC_INIT;
      presc_d   = '0;
      running_d = 1'b1;
    end else if (running_q && !in_game) begin
      // Abort: stop silently, keep the seconds shown at the time of leaving.
      running_d = 1'b0;
    end else if (terminal) begin
      presc_d = '0;
      tick_d  = 1'b1;
      sec_d   = (sec_q != 7'd0) ? sec_q - 7'd1 : 7'd0;
      if (sec_q <= 7'd1) begin
        time_up_d = 1'b1;
        running_d = 1'b0;
      end
    end else if (running_q) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Decimal split of sec_left (0..99): tens digit is the number of decade
  // thresholds reached, units is the remainder after removing those decades.
  logic [8:0] decade_ge;
  logic [3:0] tens;
  logic [6:0] units;

  genvar gi;
  generate
    for (gi = 1; gi <= 9; gi++) begin : g_decade
      assign decade_ge[gi-1] = (sec_q >= 7'(gi * 10));
    end
  endgenerate

  // Count reached thresholds and form both ASCII digits.
  always_comb begin
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      tens = tens + 4'(decade_ge[i]);
    end
    units    = sec_q - ({3'b000, tens} * 7'd10);
    ascii1_d = 7'h30 + {3'b000, tens};
    ascii0_d = 7'h30 + units;
  end

  // All state and outputs registered; reset overrides every other event.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      time_up_q <= 1'b0;
      sec_q     <= 7'd0;
      presc_q   <= '0;
      ascii1_q  <= 7'h30;
      ascii0_q  <= 7'h30;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      time_up_q <= time_up_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      ascii1_q  <= ascii1_d;
      ascii0_q  <= ascii0_d;
    end
  end

  assign running  = running_q;
  assign tick_1hz = tick_q;
  assign time_up  = time_up_q;
  assign sec_left = sec_q;
  assign ascii_1  = ascii1_q;
  assign ascii_0  = ascii0_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: CLK_FREQ=10 with ROUND_SEC=3 (instance a)
// and ROUND_SEC=30 (instance b, used for two-digit ASCII checks).
`timescale 1ns/1ps
module tb_round_timer;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GAME  = 2'b10;
  localparam logic [1:0] S_SCORE = 2'b11;

  logic       pclk = 1'b0;
  logic       rst;
  logic [1:0] state;

  logic       run_a, tick_a, tup_a;
  logic [6:0] sec_a, a1_a, a0_a;
  logic       run_b, tick_b, tup_b;
  logic [6:0] sec_b, a1_b, a0_b;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  round_timer #(.CLK_FREQ(10), .ROUND_SEC(3)) dut_a (
    .pclk(pclk), .rst(rst), .state(state),
    .running(run_a), .tick_1hz(tick_a), .sec_left(sec_a),
    .time_up(tup_a), .ascii_1(a1_a), .ascii_0(a0_a)
  );

  round_timer #(.CLK_FREQ(10), .ROUND_SEC(30)) dut_b (
    .pclk(pclk), .rst(rst), .state(state),
    .running(run_b), .tick_1hz(tick_b), .sec_left(sec_b),
    .time_up(tup_b), .ascii_1(a1_b), .ascii_0(a0_b)
  );

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Expected seconds of a 3-second round, c cycles after the start edge.
  function automatic logic [6:0] exp_sec3(int c);
    if (c >= 30) return 7'd0;
    return 7'(3 - c / 10);
  endfunction

  task automatic test_reset();
    logic [23:0] got, exp;
    rst = 1'b1;
    state = S_IDLE;
    step();
    step();
    exp = {1'b0, 1'b0, 1'b0, 7'd0, 7'h30, 7'h30};
    got = {run_a, tick_a, tup_a, sec_a, a1_a, a0_a};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", got, exp);
    end
    got = {run_b, tick_b, tup_b, sec_b, a1_b, a0_b};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_b got=%h exp=%h", got, exp);
    end
    rst = 1'b0;
    step();
    got = {run_a, tick_a, tup_a, sec_a, a1_a, a0_a};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=%h", got, exp);
    end
    $display("reset: running=%0d sec_left=%0d", run_a, sec_a);
  endtask

  task automatic test_basic();
    logic [9:0]  got, exp;
    logic [13:0] ag, ae;
    state = S_GAME;
    for (int c = 0; c <= 31; c++) begin
      step();
      exp = {(c < 30), (c > 0 && c <= 30 && (c % 10) == 0), (c == 30), exp_sec3(c)};
      got = {run_a, tick_a, tup_a, sec_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c >= 1) begin
        ae = {7'h30, 7'h30 + exp_sec3(c - 1)};
        ag = {a1_a, a0_a};
        checks++;
        if (ag !== ae) begin
          errors++;
          $display("FAIL ascii3 c=%0d got=%h exp=%h", c, ag, ae);
        end
      end
      if (c == 1 || c == 10) begin
        ag = {a1_b, a0_b};
        checks++;
        if (ag !== {7'h33, 7'h30}) begin
          errors++;
          $display("FAIL ascii30_entry c=%0d got=%h exp=%h", c, ag, {7'h33, 7'h30});
        end
      end
      if (c == 10) begin
        checks++;
        if (sec_b !== 7'd29) begin
          errors++;
          $display("FAIL sec30_tick got=%0d exp=29", sec_b);
        end
      end
      if (c == 11) begin
        ag = {a1_b, a0_b};
        checks++;
        if (ag !== {7'h32, 7'h39}) begin
          errors++;
          $display("FAIL ascii30_29 got=%h exp=%h", ag, {7'h32, 7'h39});
        end
      end
    end
    $display("basic: round expired sec_left=%0d running=%0d", sec_a, run_a);
  endtask

  task automatic test_hold_after_expiry();
    logic [9:0] got;
    for (int c = 0; c < 200; c++) begin
      step();
      got = {run_a, tick_a, tup_a, sec_a};
      checks++;
      if (got !== 10'd0) begin
        errors++;
        $display("FAIL hold_expired c=%0d got=%h exp=000", c, got);
      end
    end
    $display("hold: 200 cycles after expiry, sec_left=%0d", sec_a);
  endtask

  task automatic test_abort();
    logic [9:0] got, exp;
    state = S_SCORE;
    step();
    state = S_GAME;
    for (int c = 0; c <= 14; c++) begin
      step();
      exp = {1'b1, (c == 10), 1'b0, exp_sec3(c)};
      got = {run_a, tick_a, tup_a, sec_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_pre c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    state = S_SCORE;
    exp = {1'b0, 1'b0, 1'b0, 7'd2};
    for (int c = 0; c <= 100; c++) begin
      step();
      got = {run_a, tick_a, tup_a, sec_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_hold c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    $display("abort: frozen sec_left=%0d running=%0d", sec_a, run_a);
  endtask

  task automatic test_restart();
    logic [9:0] got, exp;
    state = S_GAME;
    for (int c = 0; c <= 10; c++) begin
      step();
      exp = {1'b1, (c == 10), 1'b0, exp_sec3(c)};
      got = {run_a, tick_a, tup_a, sec_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    $display("restart: first tick after reload, sec_left=%0d", sec_a);
  endtask

  task automatic test_reset_mid();
    logic [23:0] got24, exp24;
    logic [9:0]  got, exp;
    step();
    step();
    rst = 1'b1;
    exp24 = {1'b0, 1'b0, 1'b0, 7'd0, 7'h30, 7'h30};
    for (int c = 0; c < 2; c++) begin
      step();
      got24 = {run_a, tick_a, tup_a, sec_a, a1_a, a0_a};
      checks++;
      if (got24 !== exp24) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%h exp=%h", c, got24, exp24);
      end
    end
    rst = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      step();
      exp = {1'b1, (c == 10), 1'b0, exp_sec3(c)};
      got = {run_a, tick_a, tup_a, sec_a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    $display("reset_mid: round restarted after release, sec_left=%0d", sec_a);
  endtask

  initial begin
    rst = 1'b1;
    state = S_IDLE;
    test_reset();
    test_basic();
    test_hold_after_expiry();
    test_abort();
    test_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
